// File: rtl/fact_engine.sv
// fact_engine: iterative factorial engine.
// A go pulse in IDLE latches n, LOAD seeds the product with one, MULT
// multiplies by a down-counter once per cycle, and DONE presents the
// registered result with a one-cycle done pulse.
// Optional feature macro: FACT_OVF_CHECK_EN (sticky overflow flag on err).
module fact_engine #(
    parameter int WIDTH = 32,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MULT,
        DONE
    } state_t;

    localparam logic [NW-1:0] CNT_ONE = 1;

    state_t           state;
    logic [NW-1:0]    cnt;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] cnt_ext;
    logic [WIDTH-1:0] prod_next;

    assign cnt_ext = {{(WIDTH-NW){1'b0}}, cnt};

`ifdef FACT_OVF_CHECK_EN
    logic [2*WIDTH-1:0] full;
    logic               ovf;

    assign full      = {{WIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, cnt_ext};
    assign prod_next = full[WIDTH-1:0];

    // Sticky overflow tracking: cleared on LOAD, set by any MULT step whose
    // upper product half is nonzero, and reported on err when DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    ovf <= 1'b0;
                    err <= 1'b0;
                end
                MULT: begin
                    if (cnt > CNT_ONE) begin
                        if (|full[2*WIDTH-1:WIDTH])
                            ovf <= 1'b1;
                    end else begin
                        err <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign prod_next = prod * cnt_ext;
    assign err       = 1'b0;
`endif

    // Control FSM and datapath: all outputs are registered here, so the
    // wrapper above never sees a combinational path from go/n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        cnt   <= n;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    prod   <= {{(WIDTH-1){1'b0}}, 1'b1};
                    result <= '0;
                    state  <= MULT;
                end
                MULT: begin
                    if (cnt > CNT_ONE) begin
                        prod <= prod_next;
                        cnt  <= cnt - CNT_ONE;
                    end else begin
                        result <= prod;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: randomized self-checking bench for fact_engine.
// The reference is the true factorial computed in 64-bit arithmetic; the
// result is its low 32 bits and overflow means the factorial reaches 2^32.
module tb_fact_engine;

    localparam int WIDTH = 32;
    localparam int NW    = 4;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [NW-1:0]    n;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    fact_engine #(.WIDTH(WIDTH), .NW(NW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .n      (n),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact factorial; 15! fits comfortably in 64 bits.
    function automatic logic [63:0] factorial(input int k);
        logic [63:0] f;
        f = 64'd1;
        for (int i = 2; i <= k; i++)
            f = f * 64'(i);
        return f;
    endfunction

    function automatic logic [31:0] expResult(input int k);
        logic [63:0] f;
        f = factorial(k);
        return f[31:0];
    endfunction

    // Partial products grow monotonically, so a step overflows exactly when
    // the full factorial does.
    function automatic logic expErr(input int k);
`ifdef FACT_OVF_CHECK_EN
        logic [63:0] f;
        f = factorial(k);
        return (f[63:32] != 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One request with operand nv. If glitch > 0, an extra go pulse is
    // sampled at that edge (always while the engine is busy or in DONE) and
    // must be ignored; n is scrambled every cycle after the accepted sample.
    task automatic applyStimulus(input int nv, input int glitch);
        int m;
        m = (nv < 1) ? 1 : nv;
        @(negedge clk);
        go = 1'b1;
        n  = NW'(nv);
        for (int k = 0; k <= m + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("busy n=%0d e=%0d", nv, k), 64'(busy), 64'(k <= m));
            checkOutput($sformatf("done n=%0d e=%0d", nv, k), 64'(done), 64'(k == m + 1));
            if (k == 1)
                checkOutput($sformatf("result_cleared n=%0d", nv), 64'(result), 64'd0);
            if (k == m + 1) begin
                checkOutput($sformatf("result n=%0d", nv), 64'(result), 64'(expResult(nv)));
                checkOutput($sformatf("err n=%0d", nv), 64'(err), 64'(expErr(nv)));
            end
            go = (k + 1 == glitch) ? 1'b1 : 1'b0;
            n  = NW'($urandom);
        end
        go = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("done_pulse_end n=%0d", nv), 64'(done), 64'd0);
        checkOutput($sformatf("result_hold n=%0d", nv), 64'(result), 64'(expResult(nv)));
        checkOutput($sformatf("err_hold n=%0d", nv), 64'(err), 64'(expErr(nv)));
    endtask

    initial begin
        int rn;
        int gl;
        rst_n = 1'b0;
        go    = 1'b0;
        n     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // Directed cases
        applyStimulus(5, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(12, 0);
        applyStimulus(13, 0);
        applyStimulus(15, 0);
        applyStimulus(6, 3);

        // Reset in the middle of an n=9 computation
        @(negedge clk);
        go = 1'b1;
        n  = 4'd9;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_result", 64'(result), 64'd0);
        checkOutput("midreset_done", 64'(done), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checkOutput($sformatf("no_done_after_reset %0d", k), 64'(done), 64'd0);
            checkOutput($sformatf("idle_busy_after_reset %0d", k), 64'(busy), 64'd0);
        end
        applyStimulus(4, 0);

        // Randomized requests, some with an ignored extra go pulse
        for (int t = 0; t < 30; t++) begin
            rn = int'($urandom_range(0, 15));
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ((rn < 1) ? 1 : rn) + 1)) : 0;
            applyStimulus(rn, gl);
            if ($urandom_range(0, 2) == 0)
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
